div_seq: RTL and testbench

Multi-cycle sequencer for the RV32M divide/remainder unit (DIV, DIVU, REM, REMU). It accepts one operation per start pulse and runs a radix-2 restoring division, one quotient bit per clock. It then drives a one-cycle done strobe with a held result. While it runs, it asserts stall so the core's enable-gated state registers (PC, register-file write) hold their values until the result is ready.

---
 rtl/div_seq_if.sv | 14 +
 rtl/div_seq.sv | 82 ++++++++
 tb/tb_div_seq.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// div_seq_if: request/response bundle between the core and the divide sequencer
interface div_seq_if #(parameter int DATA_WIDTH = 32);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] rs1;
  logic [DATA_WIDTH-1:0] rs2;
  logic                  kill;
  logic                  busy;
  logic                  stall;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  modport master(output start, op, rs1, rs2, kill, input busy, stall, done, result);
  modport slave(input start, op, rs1, rs2, kill, output busy, stall, done, result);
endinterface

// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU with stall and done strobe
module div_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t         state, state_nx;
  logic [W-1:0]   dvd, dvs, rem, result_q;
  logic [CW-1:0]  cnt;
  logic           neg_q, neg_r, sel_r;
  logic           go, s_neg1, s_neg2, div0, ovf, spec;
  logic [W-1:0]   abs1, abs2, spec_res, rem_nx, dvd_nx, q_fix, r_fix;
  logic [W+1:0]   trial;
  // operand conditioning, special-case detection and one restoring-division step
  always_comb begin
    go       = bus.start & ~bus.kill;
    s_neg1   = ~bus.op[0] & bus.rs1[W-1];
    s_neg2   = ~bus.op[0] & bus.rs2[W-1];
    abs1     = s_neg1 ? -bus.rs1 : bus.rs1;
    abs2     = s_neg2 ? -bus.rs2 : bus.rs2;
    div0     = bus.rs2 == '0;
    ovf      = ~bus.op[0] & (bus.rs1 == {1'b1, {(W-1){1'b0}}}) & (bus.rs2 == '1);
    spec     = div0 | ovf;
    spec_res = div0 ? (bus.op[1] ? bus.rs1 : '1) : (bus.op[1] ? '0 : bus.rs1);
    trial    = {1'b0, rem, dvd[W-1]} - {2'b00, dvs};
    rem_nx   = trial[W+1] ? {rem[W-2:0], dvd[W-1]} : trial[W-1:0];
    dvd_nx   = {dvd[W-2:0], ~trial[W+1]};
    q_fix    = neg_q ? -dvd : dvd;
    r_fix    = neg_r ? -rem : rem;
  end
  // next state and state-decoded outputs; kill always wins
  always_comb begin
    state_nx   = bus.kill ? IDLE :
                 state == IDLE ? (bus.start ? (spec ? DONE : CALC) : IDLE) :
                 state == CALC ? (cnt == CW'(W-1) ? FIX : CALC) :
                 state == FIX  ? DONE : IDLE;
    bus.busy   = state != IDLE;
    bus.stall  = (state == IDLE & go) | state == CALC | state == FIX;
    bus.done   = state == DONE;
    bus.result = result_q;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  // datapath: latch magnitudes on accept, shift/subtract in CALC, sign-fix and load result in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      cnt      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      sel_r    <= 1'b0;
      result_q <= '0;
    end else begin
      if (state == IDLE && go) begin
        dvd   <= abs1;
        dvs   <= abs2;
        rem   <= '0;
        cnt   <= '0;
        neg_q <= s_neg1 ^ s_neg2;
        neg_r <= s_neg1;
        sel_r <= bus.op[1];
        if (spec) result_q <= spec_res;
      end
      if (state == CALC) begin
        rem <= rem_nx;
        dvd <= dvd_nx;
        cnt <= cnt + CW'(1);
      end
      if (state == FIX && !bus.kill) result_q <= sel_r ? r_fix : q_fix;
    end
  end
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard-based self-checking bench for div_seq
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  div_seq_if #(.DATA_WIDTH(32)) bus ();
  div_seq #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    if (b == 32'h0) return o[1] ? a : 32'hFFFFFFFF;
    if (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return o[1] ? 32'h0 : a;
    if (o[0]) return o[1] ? a % b : a / b;
    return o[1] ? $unsigned($signed(a) % $signed(b)) : $unsigned($signed(a) / $signed(b));
  endfunction

  function automatic int ref_lat(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    return (b == 32'h0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) ? 1 : 34;
  endfunction

  task automatic run_op(input string nm, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    logic got;
    logic [31:0] e;
    exp_q.push_back(exp);
    bus.op = o;
    bus.rs1 = a;
    bus.rs2 = b;
    bus.start = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL %s stall_start got=%b want=1", nm, bus.stall);
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      n++;
      if (bus.done === 1'b1) got = 1'b1;
    end
    e = exp_q.pop_front();
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s timeout no done within %0d cycles", nm, n);
    end else begin
      if (n !== lat) begin
        errors++;
        $display("FAIL %s latency got=%0d want=%0d", nm, n, lat);
      end
      checks++;
      if (bus.result !== e) begin
        errors++;
        $display("FAIL %s result got=%h want=%h", nm, bus.result, e);
      end
      checks++;
      if (bus.stall !== 1'b0) begin
        errors++;
        $display("FAIL %s stall_done got=%b want=0", nm, bus.stall);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.op = 2'b00;
    bus.rs1 = '0;
    bus.rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.stall !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b stall=%b result=%h want 0 0 0 0",
               bus.busy, bus.done, bus.stall, bus.result);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_unsigned();
    run_op("divu", 2'b01, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu", 2'b11, 32'd100, 32'd7, 32'd2, 34);
  endtask

  task automatic test_signed();
    run_op("div_neg", 2'b00, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 34);
    run_op("rem_neg", 2'b10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 34);
  endtask

  task automatic test_div_zero();
    run_op("div_by0", 2'b00, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1);
    run_op("rem_by0", 2'b10, 32'h12345678, 32'h0, 32'h12345678, 1);
  endtask

  task automatic test_overflow();
    run_op("div_ovf", 2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      logic [1:0] o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 3) b = 32'hFFFFFFFF;
      run_op($sformatf("rand%0d", i), o, a, b, ref_div(o, a, b), ref_lat(o, a, b));
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_a", 2'b01, 32'd5000, 32'd9, ref_div(2'b01, 32'd5000, 32'd9), 34);
    run_op("b2b_b", 2'b00, 32'hFFFFEC78, 32'd3, ref_div(2'b00, 32'hFFFFEC78, 32'd3), 34);
    run_op("b2b_c", 2'b10, 32'd77, 32'h0, 32'd77, 1);
    bus.op = 2'b01;
    bus.rs1 = 32'd50;
    bus.rs2 = 32'd5;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ignore done got=%b want=1", bus.done);
    end
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.result !== 32'd10) begin
      errors++;
      $display("FAIL b2b_ignore busy=%b result=%h want busy=0 result=%h", bus.busy, bus.result, 32'd10);
    end
  endtask

  task automatic test_kill();
    logic [31:0] prev;
    logic seen;
    prev = bus.result;
    seen = 1'b0;
    bus.start = 1'b1;
    bus.kill = 1'b1;
    bus.op = 2'b01;
    bus.rs1 = 32'd99;
    bus.rs2 = 32'd4;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL kill_prio stall got=%b want=0", bus.stall);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL kill_prio busy got=%b want=0", bus.busy);
    end
    bus.kill = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) begin
      if (c == 5) begin
        bus.start = 1'b1;
        bus.rs1 = 32'd7;
        bus.rs2 = 32'd0;
      end else bus.start = 1'b0;
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL kill_calc busy got=%b want=1", bus.busy);
    end
    bus.start = 1'b0;
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    if (bus.done === 1'b1) seen = 1'b1;
    checks++;
    if (bus.busy !== 1'b0 || seen !== 1'b0 || bus.result !== prev) begin
      errors++;
      $display("FAIL kill_abort busy=%b done_seen=%b result=%h want busy=0 done_seen=0 result=%h",
               bus.busy, seen, bus.result, prev);
    end
    run_op("kill_next", 2'b01, 32'd1000, 32'd3, 32'd333, 34);
  endtask

  task automatic test_async_reset();
    bus.op = 2'b01;
    bus.rs1 = 32'd12345;
    bus.rs2 = 32'd11;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'h0) begin
      errors++;
      $display("FAIL async_rst busy=%b done=%b result=%h want 0 0 0", bus.busy, bus.done, bus.result);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op("post_rst", 2'b01, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 34);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_random();
    test_back_to_back();
    test_kill();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
